// File: rtl/alu_pipe.sv
// alu_pipe: two-stage add/sub/and/xor ALU with valid/ready handshakes on both
// sides and a {ZF,SF,OF} condition-code register.
// Optional feature: define ALU_PIPE_CC_EN to let results with set_cc update cc
// when they leave the pipe; without it cc is tied to CC_RST and set_cc is ignored.
module alu_pipe #(
    parameter int         WIDTH  = 64,
    parameter logic [2:0] CC_RST = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ans,
    output logic             out_ovf,
    output logic [2:0]       cc
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    // Wrapping result of one operation.
    function automatic logic signed [WIDTH-1:0] alu_result(
        input logic [1:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Signed overflow: the wrapped result's sign disagrees with what the
    // operand signs force it to be. Logic ops never overflow.
    function automatic logic alu_ovf(
        input logic [1:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic signed [WIDTH-1:0] r
    );
        case (op)
            OP_ADD:  return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            default: return 1'b0;
        endcase
    endfunction

    // Stage 1 (operands) and stage 2 (result) state.
    logic                    vld_p1_q, vld_p1_d;
    logic [1:0]              op_p1_q;
    logic signed [WIDTH-1:0] a_p1_q;
    logic signed [WIDTH-1:0] b_p1_q;
    logic                    setcc_p1_q;

    logic                    vld_p2_q, vld_p2_d;
    logic signed [WIDTH-1:0] ans_p2_q, ans_p2_d;
    logic                    ovf_p2_q, ovf_p2_d;
    logic                    setcc_p2_q;

    logic                    adv_p2;
    logic                    acc_p1;

    // Stage 2 can take a new entry when it is empty or is being drained.
    assign adv_p2   = !vld_p2_q || out_ready;
    // Stage 1 can take a request when empty or when it moves into stage 2.
    assign in_ready = !vld_p1_q || adv_p2;
    assign acc_p1   = in_valid && in_ready;

    // Valid bits follow the handshakes; a stalled stage keeps its entry.
    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        if (in_ready) begin
            vld_p1_d = in_valid;
        end
        if (adv_p2) begin
            vld_p2_d = vld_p1_q;
        end
    end

    // Pipeline valid bits; reset flushes every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // ---- stage 1 -> stage 2 boundary: evaluate the ALU on registered operands
    always_comb begin
        ans_p2_d = alu_result(op_p1_q, a_p1_q, b_p1_q);
        ovf_p2_d = alu_ovf(op_p1_q, a_p1_q, b_p1_q, ans_p2_d);
    end

    // Datapath registers load only on a transfer; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (acc_p1) begin
            op_p1_q    <= in_op;
            a_p1_q     <= in_a;
            b_p1_q     <= in_b;
            setcc_p1_q <= in_set_cc;
        end
        if (adv_p2 && vld_p1_q) begin
            ans_p2_q   <= ans_p2_d;
            ovf_p2_q   <= ovf_p2_d;
            setcc_p2_q <= setcc_p1_q;
        end
    end

    // ---- stage 2 -> output: result fields read as zero while nothing is presented
    assign out_valid = vld_p2_q;
    assign out_ans   = vld_p2_q ? ans_p2_q : '0;
    assign out_ovf   = vld_p2_q && ovf_p2_q;

`ifdef ALU_PIPE_CC_EN
    logic [2:0] cc_q, cc_d;

    // Flags capture the result at its output handshake when it asked for it.
    always_comb begin
        cc_d = cc_q;
        if (vld_p2_q && out_ready && setcc_p2_q) begin
            cc_d = {(ans_p2_q == '0), ans_p2_q[WIDTH-1], ovf_p2_q};
        end
    end

    // Condition-code register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CC_RST;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc = cc_q;
`else
    // Flags are fixed; the carried set_cc bit has no consumer in this build.
    logic unused_setcc;
    assign unused_setcc = setcc_p2_q;
    assign cc = CC_RST;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a queue-based reference model checked every
// negative clock edge, directed cases with literal expectations, random traffic,
// mid-pipeline reset, and an 8-bit instance for narrow-width behaviour.
module tb_alu_pipe;

    localparam int         W      = 64;
    localparam logic [2:0] CC_RST = 3'b100;

`ifdef ALU_PIPE_CC_EN
    localparam logic [2:0] CC_AFTER_OVF = 3'b011;
`else
    localparam logic [2:0] CC_AFTER_OVF = 3'b100;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_set_cc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_ans;
    logic         out_ovf;
    logic [2:0]   cc;

    logic         v8 = 1'b0;
    logic         r8;
    logic [1:0]   op8 = 2'b00;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         sc8 = 1'b0;
    logic         ov8;
    logic         ordy8 = 1'b1;
    logic [7:0]   ans8;
    logic         ovf8;
    logic [2:0]   cc8;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .CC_RST(CC_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ans(out_ans), .out_ovf(out_ovf), .cc(cc)
    );

    alu_pipe #(.WIDTH(8), .CC_RST(CC_RST)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8), .in_op(op8),
        .in_a(a8), .in_b(b8), .in_set_cc(sc8),
        .out_valid(ov8), .out_ready(ordy8),
        .out_ans(ans8), .out_ovf(ovf8), .cc(cc8)
    );

    typedef struct {
        logic [63:0] ans;
        logic        ovf;
        logic        setcc;
        int          age;
    } exp_t;

    exp_t       q[$];
    logic [2:0] exp_cc = CC_RST;
    int         checks = 0;
    int         errors = 0;
    int         accepted = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact 65-bit signed result, overflow when it falls
    // outside the 64-bit signed range.
    function automatic void golden(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] ans, output logic ovf);
        longint            sa, sb;
        logic signed [64:0] wa, wb, wide, maxp, minn;
        sa = a;
        sb = b;
        wa = sa;
        wb = sb;
        maxp = 64'sh7FFF_FFFF_FFFF_FFFF;
        minn = 64'sh8000_0000_0000_0000;
        ovf = 1'b0;
        wide = '0;
        case (op)
            2'b00: wide = wa + wb;
            2'b01: wide = wa - wb;
            default: wide = '0;
        endcase
        if (op == 2'b10) ans = a & b;
        else if (op == 2'b11) ans = a ^ b;
        else begin
            ans = wide[63:0];
            ovf = (wide > maxp) || (wide < minn);
        end
    endfunction

    // Model + compare: every negative edge check outputs, then apply the
    // handshakes that the coming rising edge will perform.
    initial begin
        forever begin
            bit         ev, rdy;
            exp_t       e;
            logic [63:0] ga;
            logic        go;
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                exp_cc = CC_RST;
            end
            ev  = (q.size() > 0) && (q[0].age >= 2);
            rdy = !((q.size() >= 2) && !out_ready);
            check("out_valid", out_valid, ev);
            check("in_ready", in_ready, rdy);
            check("cc", cc, exp_cc);
            if (ev) begin
                check("out_ans", out_ans, q[0].ans);
                check("out_ovf", out_ovf, q[0].ovf);
            end else begin
                check("out_ans_idle", out_ans, 0);
                check("out_ovf_idle", out_ovf, 0);
            end
            if (rst_n) begin
                if (ev && out_ready) begin
`ifdef ALU_PIPE_CC_EN
                    if (q[0].setcc) exp_cc = {(q[0].ans == 0), q[0].ans[63], q[0].ovf};
`endif
                    void'(q.pop_front());
                end
                if (in_valid && rdy) begin
                    golden(in_op, in_a, in_b, ga, go);
                    e.ans = ga;
                    e.ovf = go;
                    e.setcc = in_set_cc;
                    e.age = 0;
                    q.push_back(e);
                    accepted++;
                end
                foreach (q[i]) q[i].age = q[i].age + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic sc);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_set_cc = sc;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        check("send_accept", done, 1);
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rnd();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'h1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int start;
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_cc", cc, 3'b100);
        rst_n = 1'b1;
        check("rel_in_ready", in_ready, 1);

        // Max positive + 1 wraps to min negative with overflow.
        out_ready = 1'b1;
        send(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        tick();
        check("ovf_add_valid", out_valid, 1);
        check("ovf_add_ans", out_ans, 64'h8000_0000_0000_0000);
        check("ovf_add_ovf", out_ovf, 1);
        tick();
        check("ovf_add_cc", cc, CC_AFTER_OVF);

        // Zero result, then a logic op that does not touch the flags.
        send(2'b01, 64'd5, 64'd5, 1'b1);
        tick();
        check("sub_zero_ans", out_ans, 0);
        check("sub_zero_ovf", out_ovf, 0);
        tick();
        check("sub_zero_cc", cc, 3'b100);
        send(2'b11, 64'hF0, 64'h0F, 1'b0);
        tick();
        check("xor_ans", out_ans, 64'hFF);
        check("xor_ovf", out_ovf, 0);
        tick();
        check("xor_cc", cc, 3'b100);

        // Back-pressure: two fit, third stalls, results drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b00; in_a = 64'd1; in_b = 64'd2; in_set_cc = 1'b0;
        @(negedge clk);
        check("bp_rdy1", in_ready, 1);
        tick();
        in_a = 64'd10; in_b = 64'd20;
        @(negedge clk);
        check("bp_rdy2", in_ready, 1);
        tick();
        in_op = 2'b11; in_a = 64'd5; in_b = 64'd3;
        @(negedge clk);
        check("bp_rdy3", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_frozen_valid", out_valid, 1);
            check("bp_frozen_ans", out_ans, 64'd3);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_res2", out_ans, 64'd30);
        tick();
        check("bp_res3", out_ans, 64'd6);
        tick();
        check("bp_empty", out_valid, 0);

        // Random traffic with random stalls on both sides.
        start = accepted;
        cyc = 0;
        while ((accepted - start) < 100 && cyc < 5000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 2'($urandom_range(0, 3));
            in_a      = rnd();
            in_b      = rnd();
            in_set_cc = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("rand_accepted", ((accepted - start) >= 100), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("rand_drained", q.size(), 0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(2'b00, 64'd1, 64'd1, 1'b1);
        send(2'b01, 64'd9, 64'd4, 1'b1);
        tick();
        check("full_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cc", cc, 3'b100);
        check("mid_rst_ans", out_ans, 0);
        check("mid_rst_rdy", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        check("mid_rel_rdy", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_stale", out_valid, 0);
        end

        // Narrow instance.
        ordy8 = 1'b1;
        v8 = 1'b1; op8 = 2'b10; a8 = 8'hC3; b8 = 8'h3C; sc8 = 1'b1;
        #1;
        check("w8_rdy", r8, 1);
        tick();
        v8 = 1'b0;
        tick();
        check("w8_and_valid", ov8, 1);
        check("w8_and_ans", ans8, 8'h00);
        check("w8_and_ovf", ovf8, 0);
        tick();
        check("w8_and_cc", cc8, 3'b100);
        v8 = 1'b1; op8 = 2'b00; a8 = 8'h7F; b8 = 8'h01; sc8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        check("w8_add_ans", ans8, 8'h80);
        check("w8_add_ovf", ovf8, 1);
        tick();
        check("w8_add_cc", cc8, CC_AFTER_OVF);
        check("w8_idle", ov8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
